// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - ID-stage branch request and redirect/statistics bundle
interface branch_resolve_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 id_valid;
    logic [1:0]           id_br_type;
    logic                 id_is_reg;
    logic                 id_operand_ready;
    logic                 id_zero;
    logic [0:WIDTH-1]     id_pc_plus4;
    logic [0:WIDTH-1]     id_offset;
    logic [0:WIDTH-1]     id_reg_target;

    logic                 stall_id;
    logic                 redirect;
    logic [0:WIDTH-1]     redirect_pc;
    logic                 flush_if;
    logic [0:CNT_WIDTH-1] branch_count;
    logic [0:CNT_WIDTH-1] taken_count;

    modport master (
        output id_valid, id_br_type, id_is_reg, id_operand_ready, id_zero,
               id_pc_plus4, id_offset, id_reg_target,
        input  stall_id, redirect, redirect_pc, flush_if, branch_count, taken_count
    );

    modport slave (
        input  id_valid, id_br_type, id_is_reg, id_operand_ready, id_zero,
               id_pc_plus4, id_offset, id_reg_target,
        output stall_id, redirect, redirect_pc, flush_if, branch_count, taken_count
    );
endinterface

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - decode-stage BEQZ/BNEZ/J/JR resolution with stall, redirect and stats
module branch_resolve #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic            clock,
    input  logic            reset,
    branch_resolve_if.slave br_if
);
    typedef enum logic [1:0] {
        S_RESOLVE = 2'd0,
        S_WAIT    = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 redirect_q, redirect_d;
    logic                 flush_q, flush_d;
    logic [0:WIDTH-1]     pc_q, pc_d;
    logic [0:CNT_WIDTH-1] bcnt_q, bcnt_d;
    logic [0:CNT_WIDTH-1] tcnt_q, tcnt_d;

    logic             is_beqz, is_bnez, is_uncond;
    logic             br, need_op, res, taken;
    logic [0:WIDTH-1] target;
    logic             stall;

    always_comb begin
        is_beqz   = (br_if.id_br_type == 2'b01);
        is_bnez   = (br_if.id_br_type == 2'b10);
        is_uncond = (br_if.id_br_type == 2'b11);
        br        = br_if.id_valid & (br_if.id_br_type != 2'b00);
        need_op   = is_beqz | is_bnez | (is_uncond & br_if.id_is_reg);
        res       = br & (~need_op | br_if.id_operand_ready);
        // id_zero only matters once res is true, which already implies a ready operand
        taken     = (is_beqz & br_if.id_zero) | (is_bnez & ~br_if.id_zero) | is_uncond;
        target    = (is_uncond & br_if.id_is_reg) ? br_if.id_reg_target
                                                  : br_if.id_pc_plus4 + br_if.id_offset;
    end

    always_comb begin
        state_d    = state_q;
        redirect_d = 1'b0;
        flush_d    = 1'b0;
        pc_d       = pc_q;
        bcnt_d     = bcnt_q;
        tcnt_d     = tcnt_q;
        stall      = 1'b0;

        case (state_q)
            S_RESOLVE, S_WAIT: begin
                if (res) begin
                    if (bcnt_q != '1) bcnt_d = bcnt_q + 1'b1;
                    if (taken) begin
                        if (tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
                        redirect_d = 1'b1;
                        flush_d    = 1'b1;
                        pc_d       = target;
                        state_d    = S_FLUSH;
                    end else begin
                        state_d = S_RESOLVE;
                    end
                end else if (br) begin
                    stall   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    // includes an upstream squash (id_valid dropped) while waiting
                    state_d = S_RESOLVE;
                end
            end
            S_FLUSH: begin
                state_d = S_RESOLVE;
            end
            default: begin
                state_d = S_RESOLVE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_RESOLVE;
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
            pc_q       <= '0;
            bcnt_q     <= '0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            redirect_q <= redirect_d;
            flush_q    <= flush_d;
            pc_q       <= pc_d;
            bcnt_q     <= bcnt_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign br_if.stall_id     = stall & ~reset;
    assign br_if.redirect     = redirect_q;
    assign br_if.flush_if     = flush_q;
    assign br_if.redirect_pc  = pc_q;
    assign br_if.branch_count = bcnt_q;
    assign br_if.taken_count  = tcnt_q;
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Decode-stage branch resolution unit; directly downstream of the operand zero detector, consuming its `z` flag for rs1.
- Decides BEQZ/BNEZ/J/JR outcome and stalls ID while rs1 is not yet available.
- Issues a registered one-cycle PC redirect plus IF flush on a taken branch.
- Keeps saturating branch/taken statistics counters.

Parameters:
- WIDTH, 32, datapath/PC width; all buses declared [0:WIDTH-1], bit 0 = MSB.
- CNT_WIDTH, 16, width of statistics counters.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID stage holds a valid instruction.
- id_br_type  input  2  00 none, 01 BEQZ, 10 BNEZ, 11 unconditional (J/JAL/JR/JALR).
- id_is_reg  input  1  target taken from register; meaningful only with type 11.
- id_operand_ready  input  1  rs1 value valid (register file or forward) this cycle.
- id_zero  input  1  zero-detector output for rs1 (1 = rs1 all zeros).
- id_pc_plus4  input  WIDTH  PC of branch + 4.
- id_offset  input  WIDTH  sign-extended branch/jump offset.
- id_reg_target  input  WIDTH  rs1 value for JR/JALR.
- stall_id  output  1  combinational; hold PC and IF/ID register this cycle.
- redirect  output  1  registered; fetch from redirect_pc next cycle.
- redirect_pc  output  WIDTH  registered target PC.
- flush_if  output  1  registered; squash the instruction currently in IF/ID.
- branch_count  output  CNT_WIDTH  resolved branches, saturating.
- taken_count  output  CNT_WIDTH  taken branches, saturating.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. On reset:
  - state = RESOLVE.
  - redirect, flush_if, redirect_pc, branch_count, taken_count all cleared to 0.
  - stall_id = 0 while reset is asserted.
- Branch condition: br = id_valid & (id_br_type != 00).
- Operand requirement: need_op = (type 01 or 10) or (type 11 & id_is_reg).
- Resolvable: res = br & (~need_op | id_operand_ready).
- Taken: taken = (type01 & id_zero) | (type10 & ~id_zero) | type11.
  - id_zero is sampled only when id_operand_ready = 1.
  - Type 11 with ~id_is_reg ignores id_zero and ready.
- Target:
  - id_is_reg & type11: id_reg_target.
  - Otherwise: id_pc_plus4 + id_offset, modulo 2^WIDTH; wrap-around is silent.
- FSM states: RESOLVE, WAIT, FLUSH.
- RESOLVE:
  - br & ~res: stall_id = 1, next state WAIT.
  - res & taken: next state FLUSH; next cycle redirect = 1, flush_if = 1, redirect_pc = target.
  - res & ~taken: stay in RESOLVE; redirect stays 0.
- WAIT:
  - stall_id = ~res while id_valid.
  - When res: resolve exactly as in RESOLVE in the same cycle (stall_id = 0 that cycle).
  - id_valid drops (upstream squash): return to RESOLVE, no count, no redirect.
- FLUSH:
  - Lasts exactly one cycle. redirect and flush_if are high.
  - id_valid and other ID inputs are ignored; stall_id = 0. Next state RESOLVE.
  - redirect and flush_if clear on the following edge unless a new taken resolve occurs. A new resolve is impossible because FLUSH ignores inputs.
- Resolve latency: redirect asserted 1 cycle after the resolving edge.
- Branch penalty: 1 flushed slot.
- Counters:
  - branch_count += 1 on every resolve (taken or not).
  - taken_count += 1 on taken resolves.
  - Both saturate at all-ones and never wrap.
- redirect_pc holds its last value when redirect = 0.
- Simultaneous events:
  - Resolve with counter at max: count holds; redirect still occurs.
  - Reset during WAIT or FLUSH: abort immediately; no redirect emitted after reset deasserts.
- Non-branch instructions (type 00) never stall and never count.

Test Plan:
- BEQZ, ready = 1, id_zero = 1, pc_plus4 = 0x100, offset = 0x20 → next cycle redirect = 1, flush_if = 1, redirect_pc = 0x120; counts 1/1.
- BNEZ, ready = 1, id_zero = 1 → no redirect, stall_id = 0; branch_count = 1, taken_count = 0.
- BEQZ with ready = 0 for 3 cycles, then ready = 1 with id_zero = 1:
  - stall_id = 1 for those 3 cycles, 0 on the ready cycle.
  - Redirect one cycle later; branch_count increments once.
- JR, id_reg_target = 0xDEADBEE0, ready = 0 then 1 → stalls one cycle, then redirect_pc = 0xDEADBEE0.
- J with pc_plus4 = 0xFFFFFFFC, offset = 0x8 → redirect_pc = 0x00000004 (wrap); no stall regardless of ready.
- Reset asserted mid-WAIT → all outputs 0 immediately; after deassert, state RESOLVE, no redirect.
- Preload counters at 0xFFFF, then a taken branch → both counters remain 0xFFFF; redirect = 1.
